quiz_round_ctrl: RTL

- Synchronous round sequencer for the two-player quiz game.
- Arbitrates which joystick owns each question, judges the choice against the current question's answer, and keeps both scores.
- Advances the question index, detects the winner, and drives the question ROM index and the score LED decoders.
- Replaces the free-running trigger/counter chain with one clocked controller.

---
 rtl/quiz_pkg.sv | 21 ++
 rtl/quiz_press_detect.sv | 34 +++
 rtl/quiz_round_ctrl.sv | 156 +++++++++++++++
 3 files changed

// File: rtl/quiz_pkg.sv
// Shared types and default sizing for the two-player quiz round controller.
package quiz_pkg;

  localparam int NUM_Q_DEF       = 5;
  localparam int WIN_SCORE_DEF   = 5;
  localparam int HOLD_CYCLES_DEF = 16;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ASK    = 2'd1,
    RESULT = 2'd2,
    OVER   = 2'd3
  } state_t;

  typedef enum logic [1:0] {
    WIN_NONE  = 2'b00,
    WIN_LEFT  = 2'b01,
    WIN_RIGHT = 2'b10
  } winner_t;

endpackage

// File: rtl/quiz_press_detect.sv
// Edge-qualified joystick press detector: a press is a one-hot value arriving
// after a cycle with every button released.
module quiz_press_detect (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] joy,
  output logic       press,
  output logic [1:0] choice
);

  logic [3:0] prev;
  logic       one_hot;

  always_ff @(posedge clk) begin
    if (rst) prev <= 4'b0000;
    else     prev <= joy;
  end

  // NOTE: every always_comb output gets a default first, so no path infers a latch.
  always_comb begin
    one_hot = 1'b0;
    choice  = 2'd0;
    case (joy)
      4'b0001: begin one_hot = 1'b1; choice = 2'd0; end
      4'b0010: begin one_hot = 1'b1; choice = 2'd1; end
      4'b0100: begin one_hot = 1'b1; choice = 2'd2; end
      4'b1000: begin one_hot = 1'b1; choice = 2'd3; end
      default: begin one_hot = 1'b0; choice = 2'd0; end
    endcase
  end

  assign press = one_hot && (prev == 4'b0000);

endmodule

// File: rtl/quiz_round_ctrl.sv
// Round sequencer: arbitrates joystick ownership per question, judges answers,
// keeps scores, advances questions and declares the winner.
module quiz_round_ctrl
  import quiz_pkg::*;
#(
  parameter int NUM_Q       = NUM_Q_DEF,
  parameter int WIN_SCORE   = WIN_SCORE_DEF,
  parameter int HOLD_CYCLES = HOLD_CYCLES_DEF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [3:0] joy_l,
  input  logic [3:0] joy_r,
  input  logic [1:0] ans,
  output logic [2:0] q_index,
  output logic [2:0] score_l,
  output logic [2:0] score_r,
  output logic       grant_l,
  output logic       grant_r,
  output logic       correct,
  output logic       game_over,
  output logic [1:0] winner
);

  localparam int         HW      = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [HW-1:0] HOLD_LD = HW'(HOLD_CYCLES - 1);
  localparam logic [2:0] LAST_Q  = 3'(NUM_Q - 1);
  localparam logic [2:0] WIN_S   = 3'(WIN_SCORE);

  state_t        state;
  logic [HW-1:0] hold_cnt;
  logic          lock_l, lock_r;
  logic          tie_pri;      // 0: left wins a tie, 1: right wins a tie

  logic       press_l, press_r;
  logic [1:0] choice_l, choice_r;
  logic       elig_l, elig_r, take_l, take_r, hit;
  logic [1:0] win_choice;

  quiz_press_detect u_det_l (
    .clk    (clk),
    .rst    (rst),
    .joy    (joy_l),
    .press  (press_l),
    .choice (choice_l)
  );

  quiz_press_detect u_det_r (
    .clk    (clk),
    .rst    (rst),
    .joy    (joy_r),
    .press  (press_r),
    .choice (choice_r)
  );

  always_comb begin
    elig_l     = press_l && !lock_l;
    elig_r     = press_r && !lock_r;
    take_l     = elig_l && (!elig_r || !tie_pri);
    take_r     = elig_r && (!elig_l ||  tie_pri);
    win_choice = take_l ? choice_l : choice_r;
    hit        = (win_choice == ans);
  end

  function automatic logic [2:0] sat_inc(input logic [2:0] s);
    return (s >= WIN_S) ? s : s + 3'd1;
  endfunction

  function automatic logic [2:0] next_q(input logic [2:0] q);
    return (q == LAST_Q) ? 3'd0 : q + 3'd1;
  endfunction

  // NOTE: all state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: plain control registers only; every one gets a reset value.
      state     <= IDLE;
      hold_cnt  <= '0;
      q_index   <= 3'd0;
      score_l   <= 3'd0;
      score_r   <= 3'd0;
      grant_l   <= 1'b0;
      grant_r   <= 1'b0;
      correct   <= 1'b0;
      game_over <= 1'b0;
      winner    <= WIN_NONE;
      lock_l    <= 1'b0;
      lock_r    <= 1'b0;
      tie_pri   <= 1'b0;
    end else begin
      case (state)
        IDLE, OVER: begin
          if (start) begin
            state     <= ASK;
            q_index   <= 3'd0;
            score_l   <= 3'd0;
            score_r   <= 3'd0;
            lock_l    <= 1'b0;
            lock_r    <= 1'b0;
            winner    <= WIN_NONE;
            game_over <= 1'b0;
          end
        end

        ASK: begin
          if (take_l || take_r) begin
            if (elig_l && elig_r) tie_pri <= ~tie_pri;
            grant_l  <= take_l;
            grant_r  <= take_r;
            correct  <= hit;
            if (take_l) begin
              if (hit) score_l <= sat_inc(score_l);
              else     lock_l  <= 1'b1;
            end else begin
              if (hit) score_r <= sat_inc(score_r);
              else     lock_r  <= 1'b1;
            end
            hold_cnt <= HOLD_LD;
            state    <= RESULT;
          end
        end

        RESULT: begin
          if (hold_cnt != '0) begin
            hold_cnt <= hold_cnt - HW'(1);
          end else begin
            grant_l <= 1'b0;
            grant_r <= 1'b0;
            correct <= 1'b0;
            if (correct && grant_l && score_l == WIN_S) begin
              state     <= OVER;
              winner    <= WIN_LEFT;
              game_over <= 1'b1;
            end else if (correct && grant_r && score_r == WIN_S) begin
              state     <= OVER;
              winner    <= WIN_RIGHT;
              game_over <= 1'b1;
            end else if (correct || (grant_l && lock_r) || (grant_r && lock_l)) begin
              q_index <= next_q(q_index);
              lock_l  <= 1'b0;
              lock_r  <= 1'b0;
              state   <= ASK;
            end else begin
              // Wrong answer with the opponent still free: same question, opponent only.
              state <= ASK;
            end
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule
